avalon_pio_ext: RTL



---
 rtl/avalon_pio_ext.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/avalon_pio_ext.sv
// ----------------------------------------------------------------------------
// avalon_pio_ext
// Parametrised Avalon-MM slave GPIO. It provides per-bit direction control, a
// two-flop input synchroniser, edge capture and a maskable level interrupt.
//
// Register map (word addresses):
//   0 DATA      write: data_out; read: data_out where dir=1, synced pin where dir=0
//   1 DIR       read/write, 1 = output
//   2 IRQ_MASK  read/write
//   3 EDGE_CAP  read; write-1-to-clear (a same-cycle detect wins)
//   4 OUTSET    PIO_BITSET_EN only: data_out |= writedata, reads data_out
//   5 OUTCLR    PIO_BITSET_EN only: data_out &= ~writedata, reads data_out
//   6,7         read 0, writes ignored (also 4,5 without PIO_BITSET_EN)
//
// Optional feature macro: PIO_BITSET_EN (atomic set/clear of output bits).
//
// Ports:
//   clk         system clock
//   reset_n     synchronous active-low reset
//   address     register word address
//   chipselect  Avalon slave select
//   write_n     active-low write strobe
//   writedata   write data; only [WIDTH-1:0] is used
//   readdata    registered read data, latency 1, upper bits zero
//   in_port     asynchronous pin inputs
//   out_port    output data register
//   oe          per-bit output enable (direction register)
//   irq         registered level interrupt
// ----------------------------------------------------------------------------
module avalon_pio_ext #(
   parameter int unsigned      WIDTH       = 8,
   parameter int unsigned      EDGE_TYPE   = 0,   // 0 rising, 1 falling, 2 any
   parameter logic [WIDTH-1:0] RESET_VALUE = '0,
   parameter logic [WIDTH-1:0] RESET_DIR   = '0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic [WIDTH-1:0] out_port,
   output logic [WIDTH-1:0] oe,
   output logic             irq
);

   localparam logic [2:0] ADDR_DATA   = 3'd0;
   localparam logic [2:0] ADDR_DIR    = 3'd1;
   localparam logic [2:0] ADDR_MASK   = 3'd2;
   localparam logic [2:0] ADDR_EDGE   = 3'd3;
`ifdef PIO_BITSET_EN
   localparam logic [2:0] ADDR_OUTSET = 3'd4;
   localparam logic [2:0] ADDR_OUTCLR = 3'd5;
`endif

   logic [WIDTH-1:0] data_out_q, data_out_d;
   logic [WIDTH-1:0] dir_q, dir_d;
   logic [WIDTH-1:0] mask_q, mask_d;
   logic [WIDTH-1:0] edge_q, edge_d;
   logic [WIDTH-1:0] sync1_q, sync2_q, prev_q;
   logic [31:0]      readdata_q, readdata_d;
   logic             irq_q, irq_d;

   logic             wr;
   logic [WIDTH-1:0] wd;
   logic [WIDTH-1:0] clr;
   logic [WIDTH-1:0] det;

   // Upper write-data bits are architecturally ignored.
   logic unused_wd;
   assign unused_wd = ^writedata;

   assign wr = chipselect & ~write_n;
   assign wd = writedata[WIDTH-1:0];

   // NOTE: every signal assigned in always_comb gets a default first so no
   // path through the block leaves it unassigned (which would infer a latch).
   always_comb begin
      data_out_d = data_out_q;
      dir_d      = dir_q;
      mask_d     = mask_q;
      clr        = '0;
      if (wr) begin
         case (address)
            ADDR_DATA:   data_out_d = wd;
            ADDR_DIR:    dir_d      = wd;
            ADDR_MASK:   mask_d     = wd;
            ADDR_EDGE:   clr        = wd;
`ifdef PIO_BITSET_EN
            ADDR_OUTSET: data_out_d = data_out_q | wd;
            ADDR_OUTCLR: data_out_d = data_out_q & ~wd;
`endif
            default:     ;
         endcase
      end
   end

   // Edge detect on the synchronised sample against its previous value.
   always_comb begin
      case (EDGE_TYPE)
         0:       det = sync2_q & ~prev_q;
         1:       det = ~sync2_q & prev_q;
         default: det = sync2_q ^ prev_q;
      endcase
   end

   // Clear first, then OR in new detects so a coincident edge is not lost.
   assign edge_d = (edge_q & ~clr) | det;
   assign irq_d  = |(edge_q & mask_q);

   always_comb begin
      readdata_d = '0;
      case (address)
         ADDR_DATA:   readdata_d[WIDTH-1:0] = (data_out_q & dir_q) | (sync2_q & ~dir_q);
         ADDR_DIR:    readdata_d[WIDTH-1:0] = dir_q;
         ADDR_MASK:   readdata_d[WIDTH-1:0] = mask_q;
         ADDR_EDGE:   readdata_d[WIDTH-1:0] = edge_q;
`ifdef PIO_BITSET_EN
         ADDR_OUTSET: readdata_d[WIDTH-1:0] = data_out_q;
         ADDR_OUTCLR: readdata_d[WIDTH-1:0] = data_out_q;
`endif
         default:     readdata_d = '0;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values; this is what makes sync1 -> sync2 -> prev a
   // real three-stage shift rather than a single wire.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         data_out_q <= RESET_VALUE;
         dir_q      <= RESET_DIR;
         mask_q     <= '0;
         edge_q     <= '0;
         sync1_q    <= '0;
         sync2_q    <= '0;
         prev_q     <= '0;
         readdata_q <= '0;
         irq_q      <= 1'b0;
      end else begin
         data_out_q <= data_out_d;
         dir_q      <= dir_d;
         mask_q     <= mask_d;
         edge_q     <= edge_d;
         sync1_q    <= in_port;
         sync2_q    <= sync1_q;
         prev_q     <= sync2_q;
         readdata_q <= readdata_d;
         irq_q      <= irq_d;
      end
   end

   assign readdata = readdata_q;
   assign out_port = data_out_q;
   assign oe       = dir_q;
   assign irq      = irq_q;

endmodule
